// File: rtl/seq_mult_param.sv
// seq_mult_param: parametrised sequential shift-add multiplier.
// Computes the full 2*WIDTH-bit product of two WIDTH-bit operands in WIDTH+1
// cycles, with a start/done handshake and run-time signed/unsigned selection.
// Signed operation multiplies magnitudes and negates the result at the end.
module seq_mult_param #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     x1,
    input  logic [WIDTH-1:0]     x2,
    output logic [2*WIDTH-1:0]   out,
    output logic                 done,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       mag1_q, mag1_d;
    logic [WIDTH-1:0]       mag2_q, mag2_d;
    logic                   neg_q, neg_d;
    logic [2*WIDTH:0]       acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     out_q, out_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic [WIDTH:0]         add_s;

    // Magnitude of an operand; the most-negative value maps to 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v,
                                                input logic             sm);
        logic [WIDTH-1:0] r;
        if (sm && v[WIDTH-1]) begin
            r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's-complement negation at product width.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Partial-product add into the upper accumulator half (bit 2W holds the carry).
    always_comb begin
        if (mag2_q[0]) begin
            add_s = acc_q[2*WIDTH:WIDTH] + {1'b0, mag1_q};
        end else begin
            add_s = acc_q[2*WIDTH:WIDTH];
        end
    end

    // Next-state and datapath control for IDLE/CALC/DONE sequencing.
    always_comb begin
        state_d = state_q;
        mag1_d  = mag1_q;
        mag2_d  = mag2_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mag1_d  = mag_of(x1, signed_mode);
                    mag2_d  = mag_of(x2, signed_mode);
                    neg_d   = signed_mode & (x1[WIDTH-1] ^ x2[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = ST_CALC;
                end else begin
                    // Also drops busy in the cycle following a done pulse.
                    busy_d  = 1'b0;
                end
            end
            ST_CALC: begin
                acc_d  = {add_s, acc_q[WIDTH-1:0]} >> 1;
                mag2_d = mag2_q >> 1;
                cnt_d  = cnt_q - CW'(1);
                busy_d = 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                if (neg_q) begin
                    out_d = neg_2w(acc_q[2*WIDTH-1:0]);
                end else begin
                    out_d = acc_q[2*WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mag1_q  <= '0;
            mag2_q  <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag1_q  <= mag1_d;
            mag2_q  <= mag2_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign out  = out_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param: a 16-bit and an 8-bit instance.
// Drivers push expected product and expected completion cycle; monitors pop
// and compare whenever done is seen.
module tb_seq_mult_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        start16, sm16, done16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] out16;
    logic        start8, sm8, done8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] out8;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] v;
        int          c;
    } exp_t;
    exp_t q16[$];
    exp_t q8[$];

    seq_mult_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .x1(a16), .x2(b16), .out(out16), .done(done16), .busy(busy16)
    );

    seq_mult_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .x1(a8), .x2(b8), .out(out8), .done(done8), .busy(busy8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference product: plain integer multiplication, truncated to 2*w bits.
    function automatic logic [63:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input bit sm);
        longint sa, sb, p;
        logic [63:0] mask;
        sa = longint'(a);
        sb = longint'(b);
        if (sm && a[w-1]) sa = sa - (longint'(1) << w);
        if (sm && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(p) & mask;
    endfunction

    // Monitors: pop and compare on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst && done16) begin
            if (q16.size() == 0) begin
                check("unexpected_done16", 64'(done16), 64'd0);
            end else begin
                e = q16.pop_front();
                check("out16", 64'(out16), 64'(e.v));
                check("latency16", 64'(cyc), 64'(e.c));
            end
        end
        if (rst && done8) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", 64'(done8), 64'd0);
            end else begin
                e = q8.pop_front();
                check("out8", 64'(out8), 64'(e.v));
                check("latency8", 64'(cyc), 64'(e.c));
            end
        end
    end

    // One 16-bit operation; optional start pulse while busy that must be ignored.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input bit sm,
                        input logic [31:0] exp, input bit gar);
        exp_t e;
        @(negedge clk);
        start16 = 1'b1; a16 = a; b16 = b; sm16 = sm;
        e.v = exp; e.c = cyc + 1 + 17;
        q16.push_back(e);
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
        check("busy16_during", 64'(busy16), 64'd1);
        for (int i = 0; i < 40; i++) begin
            if (q16.size() == 0) break;
            @(negedge clk);
            #1;
            if (gar && i == 3) begin
                start16 = 1'b1; a16 = 16'd9; b16 = 16'd9; sm16 = 1'b0;
            end else begin
                start16 = 1'b0;
            end
        end
        if (q16.size() != 0) begin
            check("timeout16", 64'(q16.size()), 64'd0);
            q16.delete();
        end
        @(negedge clk);
        check("busy16_after", 64'(busy16), 64'd0);
    endtask

    // One 8-bit operation.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit sm);
        exp_t e;
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
        e.v = 32'(model(8, 32'(a), 32'(b), sm)); e.c = cyc + 1 + 9;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (q8.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (q8.size() != 0) begin
            check("timeout8", 64'(q8.size()), 64'd0);
            q8.delete();
        end
        @(negedge clk);
        check("busy8_after", 64'(busy8), 64'd0);
    endtask

    initial begin
        exp_t e;
        logic [15:0] ra, rb;
        bit rs;
        rst = 1'b0;
        start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        @(negedge clk);
        check("rst_out16", 64'(out16), 64'd0);
        check("rst_done16", 64'(done16), 64'd0);
        check("rst_busy16", 64'(busy16), 64'd0);
        check("rst_out8", 64'(out8), 64'd0);
        rst = 1'b1;

        // Directed cases
        op16(16'd4, 16'd5, 1'b0, 32'd20, 1'b0);
        op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b0);
        op16(16'd0, 16'h1234, 1'b0, 32'd0, 1'b0);
        op16(16'hFFFD, 16'd7, 1'b1, 32'hFFFFFFEB, 1'b0);
        op16(16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b0);
        op16(16'h8000, 16'd1, 1'b1, 32'hFFFF8000, 1'b0);
        // start pulsed mid-operation with 9*9 must be ignored
        op16(16'd4, 16'd5, 1'b0, 32'd20, 1'b1);
        repeat (25) @(negedge clk);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        start16 = 1'b1; a16 = 16'd6; b16 = 16'd7; sm16 = 1'b0;
        e.v = 32'd42; e.c = cyc + 18;
        q16.push_back(e);
        @(negedge clk);
        start16 = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_out16", 64'(out16), 64'd0);
        check("midrst_done16", 64'(done16), 64'd0);
        check("midrst_busy16", 64'(busy16), 64'd0);
        q16.delete();
        @(negedge clk);
        rst = 1'b1;
        op16(16'd2, 16'd3, 1'b0, 32'd6, 1'b0);
        repeat (25) @(negedge clk);

        // Randomised 16-bit operations
        for (int n = 0; n < 25; n++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            if (n % 8 == 1) ra = 16'h8000;
            if (n % 8 == 2) rb = 16'hFFFF;
            op16(ra, rb, rs, 32'(model(16, 32'(ra), 32'(rb), rs)), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // 8-bit instance: start held high across two back-to-back operations
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd200; b8 = 8'd3; sm8 = 1'b0;
        e.v = 32'd600; e.c = cyc + 1 + 9;
        q8.push_back(e);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h02; sm8 = 1'b1;
        e.v = 32'h0000FFFE; e.c = cyc + 10 + 9;
        q8.push_back(e);
        repeat (10) @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (q8.size() == 0) break;
            @(negedge clk);
        end
        if (q8.size() != 0) begin
            check("timeout8_held", 64'(q8.size()), 64'd0);
            q8.delete();
        end
        repeat (3) @(negedge clk);

        for (int n = 0; n < 12; n++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom));
        end
        op8(8'h80, 8'h80, 1'b1);
        op8(8'hFF, 8'hFF, 1'b0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mult_param.md
# seq_mult_param

Parametrised sequential shift-add multiplier with a start/done handshake and run-time signed/unsigned mode. It computes the full 2*WIDTH-bit product of two WIDTH-bit operands in a fixed WIDTH+1 cycles. It is the generic multiply engine for datapaths that previously used a fixed 16x16 unsigned multiplier, and it keeps the same clk/rst/start/x1/x2/out/done contract.

## Interface
- WIDTH, 16, operand width in bits (legal range 2..32); product width is 2*WIDTH
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with operands
- x1  input  WIDTH  multiplicand, captured on accepted start
- x2  input  WIDTH  multiplier, captured on accepted start
- out  output  2*WIDTH  product, registered, held until next completion
- done  output  1  single-cycle pulse, out valid in the same cycle
- busy  output  1  high while an operation is in flight (CALC and DONE states)

## Operation
- States: IDLE, CALC, DONE.
- IDLE: busy=0. If start=1 on a clock edge, accept: latch mag1=|x1|, mag2=|x2| (absolute value only when signed_mode=1, else raw), latch neg = signed_mode & (x1[MSB] ^ x2[MSB]), clear accumulator, load iteration counter to WIDTH, go to CALC.
- Magnitudes are WIDTH-bit unsigned; the most-negative input -2^(WIDTH-1) yields magnitude 2^(WIDTH-1), representable without overflow.
- CALC: each cycle, if mag2[0]=1 add mag1 into the upper half of the 2*WIDTH+1-bit accumulator, then shift accumulator and mag2 right by one; decrement counter. After WIDTH iterations go to DONE.
- DONE: out <= neg ? (two's-complement negation of accumulator, 2*WIDTH bits) : accumulator; done=1 for this cycle only; next state IDLE.
- Products never overflow 2*WIDTH bits in either mode.
- start while busy=1: ignored, no queuing, operands not re-sampled.
- start held high continuously: a new operation is accepted on the first IDLE cycle after each DONE.
- signed_mode, x1, x2 may change freely after acceptance; only captured values are used.
- Reset (rst=0) at any time, including mid-CALC: immediately IDLE, operation discarded.

## Timing
- Reset values: out=0, done=0, busy=0, state IDLE, internal registers 0.
- Edge E0 accepts start. busy=1 from E0 through the cycle of done.
- CALC occupies edges E1..EWIDTH; DONE state entered at EWIDTH; out updates and done=1 immediately after edge EWIDTH+1 is... more precisely: out and done are registered together at edge E(WIDTH+1), done deasserts at E(WIDTH+2).
- Latency: WIDTH+1 clock cycles from accepting edge to done assertion (17 for WIDTH=16).
- Throughput: one operation per WIDTH+2 cycles when start is held high.
- out changes only on the done edge; between completions it holds the previous result.
- No combinational path from any input to any output.

## Test plan
- WIDTH=16, unsigned: reset low 1 cycle, start=1 with x1=4, x2=5 for one edge -> done pulses once 17 cycles after acceptance, out=32'd20, busy low the cycle after.
- WIDTH=16, unsigned extremes: x1=x2=16'hFFFF -> out=32'hFFFE0001; x1=0, x2=16'h1234 -> out=0, done still at 17 cycles.
- WIDTH=16, signed: x1=-3 (16'hFFFD), x2=7 -> out=32'hFFFFFFEB; x1=x2=16'h8000 -> out=32'h40000000; x1=16'h8000, x2=1 -> out=32'hFFFF8000.
- Busy protection: start x1=4,x2=5, then at cycle 5 pulse start with x1=9,x2=9 -> single done, out=20; no second done without new start in IDLE.
- Reset mid-operation: start 6*7, drive rst=0 at cycle 8 (asynchronous, between edges) -> out, done, busy read 0 immediately; after release and new start 2*3 -> out=6 with normal latency.
- WIDTH=8 instance: start held high, operands 8'd200*8'd3 then signed 8'hFF*8'h02 -> out=16'd600, then 16'hFFFE, done pulses 10 cycles apart (WIDTH+2).
